// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared encodings for the MEM-stage access controller
package mem_access_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam int ADDR_LIMIT_DEFAULT = 256;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_GAP    = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// rtl/mem_access_ctrl_load_extend.sv - sign/zero extension of right-aligned load data
module load_extend
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  always_comb begin
    dout = din;
    case (size)
      SZ_BYTE: dout = {{24{sgn & din[7]}}, din[7:0]};
      SZ_HALF: dout = {{16{sgn & din[15]}}, din[15:0]};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store and block-transfer sequencer driving data_ram256x8
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int RAM_LAT    = 1,
  parameter int ADDR_LIMIT = ADDR_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqRW,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  input  logic [3:0]  ReqCount,
  output logic        WReq,
  input  logic [31:0] WData,
  output logic        RspValid,
  output logic [31:0] RspData,
  output logic        RspLast,
  output logic        Fault,
  output logic        Stall,
  output logic        RamEnable,
  output logic        RamRW,
  output logic [1:0]  RamSize,
  output logic [31:0] RamAddr,
  output logic [31:0] RamDataIn,
  input  logic [31:0] RamDataOut
);

  localparam logic [2:0] LAT_LAST = 3'(RAM_LAT - 1);

  state_t      state_q, state_d;
  logic [2:0]  lat_q, lat_d;
  logic [3:0]  beats_q, beats_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rw_q, rw_d;
  logic        signed_q, signed_d;
  logic [1:0]  size_q, size_d;
  logic        ram_en_q, ram_en_d;

  logic [3:0]  req_beats;
  logic [33:0] req_end;
  logic        req_fault;
  logic [31:0] ext_data;

  load_extend u_load_extend (
    .size (size_q),
    .sgn  (signed_q),
    .din  (RamDataOut),
    .dout (ext_data)
  );

  // Range is checked for the whole block so the incrementing address can never wrap.
  always_comb begin
    req_beats = (ReqCount == 4'd0) ? 4'd1 : ReqCount;
    req_end   = {2'b00, ReqAddr} + 34'(size_bytes(ReqSize)) * 34'(req_beats);
    req_fault = (ReqSize == SZ_BAD)
             || ((req_beats > 4'd1) && (ReqSize != SZ_WORD))
             || ((ReqSize == SZ_HALF) && ReqAddr[0])
             || ((ReqSize == SZ_WORD) && (ReqAddr[1:0] != 2'b00))
             || (req_end > 34'(ADDR_LIMIT));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      lat_q    <= '0;
      beats_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rw_q     <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= '0;
      ram_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      beats_q  <= beats_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rw_q     <= rw_d;
      signed_q <= signed_d;
      size_q   <= size_d;
      ram_en_q <= ram_en_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    beats_d  = beats_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rw_d     = rw_q;
    signed_d = signed_q;
    size_d   = size_q;
    case (state_q)
      ST_IDLE: begin
        if (ReqValid) begin
          rw_d     = ReqRW;
          size_d   = ReqSize;
          signed_d = ReqSigned;
          addr_d   = ReqAddr;
          wdata_d  = ReqWData;
          beats_d  = req_beats;
          lat_d    = '0;
          rdata_d  = '0;
          state_d  = req_fault ? ST_FAULT : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (lat_q == LAT_LAST) begin
          rdata_d = (rw_q == RW_READ) ? ext_data : 32'd0;
          state_d = ST_GAP;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      ST_GAP: begin
        if (beats_q > 4'd1) begin
          addr_d  = addr_q + 32'd4;
          beats_d = beats_q - 4'd1;
          lat_d   = '0;
          if (rw_q == RW_WRITE) wdata_d = WData;
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Enable is a flop of its own so the RAM sees a clean, registered strobe.
    ram_en_d = (state_d == ST_ACCESS);
  end

  always_comb begin
    ReqReady  = (state_q == ST_IDLE);
    Stall     = (state_q != ST_IDLE);
    RspValid  = (state_q == ST_GAP) || (state_q == ST_FAULT);
    RspLast   = (state_q == ST_FAULT) || ((state_q == ST_GAP) && (beats_q == 4'd1));
    Fault     = (state_q == ST_FAULT);
    RspData   = (state_q == ST_GAP) ? rdata_q : 32'd0;
    WReq      = (state_q == ST_GAP) && (rw_q == RW_WRITE) && (beats_q > 4'd1);
    RamEnable = ram_en_q;
    RamRW     = rw_q;
    RamSize   = size_q;
    RamAddr   = addr_q;
    RamDataIn = wdata_q;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic        ReqRW = 1'b0;
  logic [1:0]  ReqSize = 2'b00;
  logic        ReqSigned = 1'b0;
  logic [31:0] ReqAddr = '0;
  logic [31:0] ReqWData = '0;
  logic [3:0]  ReqCount = '0;
  logic        WReq;
  logic [31:0] WData = '0;
  logic        RspValid;
  logic [31:0] RspData;
  logic        RspLast;
  logic        Fault;
  logic        Stall;
  logic        RamEnable;
  logic        RamRW;
  logic [1:0]  RamSize;
  logic [31:0] RamAddr;
  logic [31:0] RamDataIn;
  logic [31:0] RamDataOut;

  logic        load_mem = 1'b1;
  logic [7:0]  mem [0:255];
  logic [7:0]  a0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.RAM_LAT(1), .ADDR_LIMIT(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .ReqValid   (ReqValid),
    .ReqReady   (ReqReady),
    .ReqRW      (ReqRW),
    .ReqSize    (ReqSize),
    .ReqSigned  (ReqSigned),
    .ReqAddr    (ReqAddr),
    .ReqWData   (ReqWData),
    .ReqCount   (ReqCount),
    .WReq       (WReq),
    .WData      (WData),
    .RspValid   (RspValid),
    .RspData    (RspData),
    .RspLast    (RspLast),
    .Fault      (Fault),
    .Stall      (Stall),
    .RamEnable  (RamEnable),
    .RamRW      (RamRW),
    .RamSize    (RamSize),
    .RamAddr    (RamAddr),
    .RamDataIn  (RamDataIn),
    .RamDataOut (RamDataOut)
  );

  // Little-endian byte RAM, read data right-aligned by size.
  assign a0 = 8'(RamAddr);

  always_comb begin
    case (RamSize)
      SZ_BYTE: RamDataOut = {24'd0, mem[a0]};
      SZ_HALF: RamDataOut = {16'd0, mem[a0 + 8'd1], mem[a0]};
      default: RamDataOut = {mem[a0 + 8'd3], mem[a0 + 8'd2], mem[a0 + 8'd1], mem[a0]};
    endcase
  end

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[0] <= 8'h85;
      mem[2] <= 8'h7F;
      mem[3] <= 8'hF0;
    end else if (RamEnable && RamRW) begin
      mem[a0] <= RamDataIn[7:0];
      if (RamSize != SZ_BYTE) mem[a0 + 8'd1] <= RamDataIn[15:8];
      if (RamSize == SZ_WORD) begin
        mem[a0 + 8'd2] <= RamDataIn[23:16];
        mem[a0 + 8'd3] <= RamDataIn[31:24];
      end
    end
  end

  function automatic logic [31:0] rd_word(input int a);
    rd_word = {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rw, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] cnt);
    ReqValid  = 1'b1;
    ReqRW     = rw;
    ReqSize   = size;
    ReqSigned = sgn;
    ReqAddr   = addr;
    ReqWData  = wd;
    ReqCount  = cnt;
    step();
    ReqValid  = 1'b0;
  endtask

  task automatic single_read(input string tag, input logic [1:0] size, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] exp);
    issue(RW_READ, size, sgn, addr, 32'd0, 4'd1);
    chk({tag, "_en"}, RamEnable, 1);
    chk({tag, "_addr"}, RamAddr, addr);
    chk({tag, "_early_rsp"}, RspValid, 0);
    step();
    chk({tag, "_rsp"}, RspValid, 1);
    chk({tag, "_data"}, RspData, exp);
    chk({tag, "_last"}, RspLast, 1);
    chk({tag, "_fault"}, Fault, 0);
    chk({tag, "_en_gap"}, RamEnable, 0);
    step();
    chk({tag, "_ready"}, ReqReady, 1);
  endtask

  task automatic fault_req(input string tag, input logic [1:0] size,
                           input logic [31:0] addr, input logic [3:0] cnt);
    issue(RW_READ, size, 1'b0, addr, 32'd0, cnt);
    chk({tag, "_rsp"}, RspValid, 1);
    chk({tag, "_fault"}, Fault, 1);
    chk({tag, "_last"}, RspLast, 1);
    chk({tag, "_data"}, RspData, 0);
    chk({tag, "_en"}, RamEnable, 0);
    step();
    chk({tag, "_ready"}, ReqReady, 1);
    chk({tag, "_en2"}, RamEnable, 0);
  endtask

  logic [31:0] ldm_exp [4];
  logic [31:0] stm_val [3];
  int wreq_cnt;
  int rsp_cnt;

  initial begin
    step();
    chk("rst_ready_in_reset", ReqReady, 1);
    chk("rst_en", RamEnable, 0);
    chk("rst_rsp", RspValid, 0);
    step();
    reset    = 1'b0;
    load_mem = 1'b0;
    step();
    chk("rst_ready", ReqReady, 1);
    chk("rst_stall", Stall, 0);
    chk("rst_wreq", WReq, 0);
    chk("rst_fault", Fault, 0);
    chk("rst_last", RspLast, 0);
    chk("rst_ramrw", RamRW, 0);
    chk("rst_addr", RamAddr, 0);
    chk("rst_din", RamDataIn, 0);
    chk("rst_size", RamSize, 0);
    chk("rst_rdata", RspData, 0);

    single_read("lb_s", SZ_BYTE, 1'b1, 32'd0, 32'hFFFF_FF85);
    single_read("lb_u", SZ_BYTE, 1'b0, 32'd0, 32'h0000_0085);
    single_read("lh_s", SZ_HALF, 1'b1, 32'd2, 32'hFFFF_F07F);
    single_read("lh_u", SZ_HALF, 1'b0, 32'd2, 32'h0000_F07F);
    fault_req("lh_mis", SZ_HALF, 32'd3, 4'd1);

    issue(RW_WRITE, SZ_WORD, 1'b1, 32'd8, 32'hDDDD_DDDD, 4'd0);
    chk("sw_en", RamEnable, 1);
    chk("sw_rw", RamRW, 1);
    chk("sw_din", RamDataIn, 32'hDDDD_DDDD);
    chk("sw_stall", Stall, 1);
    step();
    chk("sw_rsp", RspValid, 1);
    chk("sw_data", RspData, 0);
    chk("sw_wreq", WReq, 0);
    step();
    chk("sw_ready", ReqReady, 1);
    single_read("lw_back", SZ_WORD, 1'b0, 32'd8, 32'hDDDD_DDDD);

    ldm_exp = '{32'hF07F_0085, 32'h0, 32'hDDDD_DDDD, 32'h0};
    issue(RW_READ, SZ_WORD, 1'b0, 32'd0, 32'd0, 4'd4);
    for (int b = 0; b < 4; b++) begin
      chk("ldm_en", RamEnable, 1);
      chk("ldm_addr", RamAddr, 32'(4 * b));
      chk("ldm_norsp", RspValid, 0);
      step();
      chk("ldm_rsp", RspValid, 1);
      chk("ldm_data", RspData, ldm_exp[b]);
      chk("ldm_last", RspLast, (b == 3) ? 32'd1 : 32'd0);
      chk("ldm_en_gap", RamEnable, 0);
      step();
    end
    chk("ldm_ready", ReqReady, 1);

    stm_val = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    wreq_cnt = 0;
    issue(RW_WRITE, SZ_WORD, 1'b0, 32'd16, stm_val[0], 4'd3);
    for (int b = 0; b < 3; b++) begin
      chk("stm_addr", RamAddr, 32'(16 + 4 * b));
      chk("stm_din", RamDataIn, stm_val[b]);
      if (b < 2) WData = stm_val[b + 1];
      step();
      chk("stm_rsp", RspValid, 1);
      chk("stm_last", RspLast, (b == 2) ? 32'd1 : 32'd0);
      if (WReq) wreq_cnt++;
      step();
    end
    chk("stm_wreq_cnt", 32'(wreq_cnt), 2);
    chk("stm_mem16", rd_word(16), stm_val[0]);
    chk("stm_mem20", rd_word(20), stm_val[1]);
    chk("stm_mem24", rd_word(24), stm_val[2]);

    fault_req("range_252x2", SZ_WORD, 32'd252, 4'd2);
    single_read("range_252x1", SZ_WORD, 1'b0, 32'd252, 32'h0);
    fault_req("size_11", SZ_BAD, 32'd0, 4'd1);
    fault_req("half_blk", SZ_HALF, 32'd0, 4'd2);
    fault_req("word_mis", SZ_WORD, 32'd2, 4'd1);

    WData = 32'hB1B1_B1B1;
    issue(RW_WRITE, SZ_WORD, 1'b0, 32'd32, 32'hA0A0_A0A0, 4'd4);
    step();
    chk("rmid_gap", RspValid, 1);
    step();
    chk("rmid_beat1", RamAddr, 32'd36);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rmid_en", RamEnable, 0);
    chk("rmid_ready", ReqReady, 1);
    chk("rmid_rsp", RspValid, 0);
    rsp_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (RspValid || RamEnable) rsp_cnt++;
    end
    chk("rmid_quiet", 32'(rsp_cnt), 0);
    chk("rmid_keep0", rd_word(32), 32'hA0A0_A0A0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
